sap_prog_loader_ctrl: RTL
=========================

// Module: sap_prog_loader_ctrl
// PURPOSE
//  Program loader and run controller for the SAP-1 core and its 16x8 program memory.
//  Deserialises a bit stream into program bytes and writes them to memory.
//  Shares the memory port between the loader and CPU fetch.
//  Sequences the CPU through hold-in-reset, run, halt and single-step.
// PARAMETERS
//  AW  4  program memory address width (depth = 2**AW)
//  DW  8  program word width (bits per serial byte)
// PORTS
//  clk            in   1     system clock
//  rst            in   1     synchronous, active-high reset
//  ser_valid      in   1     ser_data is sampled on this cycle
//  ser_data       in   1     serial program bit, MSB first
//  load_req       in   1     enter LOAD (level, sampled each cycle)
//  run_req        in   1     enter free-running RUN
//  step_req       in   1     execute exactly one instruction, then HALT
//  halt_req       in   1     stop CPU at next instruction boundary / abort LOAD
//  cpu_mem_addr   in   AW    CPU MAR value
//  cpu_instr_done in   1     CPU in final microstep (T5) of current instruction
//  mem_addr       out  AW    memory address (loader pointer or cpu_mem_addr)
//  mem_wdata      out  DW    assembled byte to write
//  mem_we         out  1     memory write strobe, 1 cycle per byte
//  cpu_rst        out  1     holds CPU in reset
//  cpu_en         out  1     CPU clock enable
//  state          out  2     0=IDLE 1=LOAD 2=RUN 3=HALT
//  byte_cnt       out  AW+1  bytes written in current/last LOAD (0..2**AW)
//  load_done      out  1     1-cycle pulse after final byte is written
// BEHAVIOUR
//  - Reset values: state=IDLE, cpu_rst=1, cpu_en=0, mem_we=0, mem_wdata=0,
//    byte_cnt=0, load_done=0. Internal shift reg, bit count, step/halt flags = 0.
//  - Reset mid-LOAD: partial byte is lost. Memory contents are not touched.
//  - All outputs are registered except mem_addr.
//    mem_addr = cpu_mem_addr in RUN/HALT, else the loader pointer (byte_cnt[AW-1:0]).
//  - cpu_rst=1 in IDLE/LOAD, 0 in RUN/HALT. cpu_en=1 only in RUN.
//  - Request priority when simultaneous: halt_req > load_req > run_req > step_req.
//  - IDLE:
//    - halt_req: ignored.
//    - load_req: ->LOAD, clears byte_cnt and bit count.
//    - run_req: ->RUN.
//    - step_req: ->RUN with step flag set.
//  - LOAD:
//    - Each ser_valid cycle shifts ser_data into the shift reg.
//    - On the 8th bit: at the next edge mem_we=1 for one cycle, with mem_wdata=byte and mem_addr=pointer.
//      byte_cnt increments at the end of that cycle.
//    - ser_valid during the write cycle is accepted. Back-to-back bytes need no gap.
//    - After the write at address 2**AW-1: byte_cnt=2**AW, load_done=1 for one cycle, ->IDLE.
//    - halt_req: ->IDLE. Partial byte discarded, written bytes kept, byte_cnt holds, no load_done.
//    - load_req, run_req, step_req: ignored.
//  - RUN:
//    - mem_we=0.
//    - halt_req sets halt_pending (sticky).
//    - A cycle with cpu_instr_done=1 and (halt_pending, halt_req or step flag set): ->HALT at that edge,
//      so cpu_en=0 from the next cycle. Clears halt_pending and the step flag.
//    - load_req: ->LOAD immediately, abandoning the instruction.
//    - run_req, step_req: ignored.
//  - HALT:
//    - CPU state is frozen (cpu_rst=0, cpu_en=0).
//    - run_req: ->RUN.
//    - step_req: ->RUN with step flag set.
//    - load_req: ->LOAD, which re-asserts cpu_rst.
//    - halt_req: stays in HALT and blocks the lower-priority requests.
//  - Wrap: loader pointer never wraps. LOAD always ends after 2**AW bytes.
// TESTING
//  1. Assert rst 2 cycles -> state=0, cpu_rst=1, cpu_en=0, mem_we=0, byte_cnt=0.
//  2. load_req, then 128 back-to-back bits of bytes 0x0E,0x1F,0x2D,...
//     -> 16 mem_we pulses at addr 0..15 with matching data, load_done once, state=0.
//  3. LOAD with 20 bits then halt_req -> writes only 0x0E@0 and 0x1F@1,
//     byte_cnt=2, no load_done, state=0.
//  4. run_req in IDLE -> next cycle state=2, cpu_rst=0, cpu_en=1;
//     cpu_mem_addr=0x9 -> mem_addr=0x9.
//  5. RUN, halt_req pulse, cpu_instr_done 3 cycles later
//     -> cpu_en=1 through the done cycle, then cpu_en=0, state=3.
//  6. HALT, step_req -> RUN until first cpu_instr_done, then HALT;
//     halt_req+run_req together in HALT -> stays HALT.

Source files
------------

// File: rtl/sap_prog_loader_ctrl.sv
// ---------------------------------------------------------------------------
// sap_prog_loader_ctrl
//
// Program loader and run controller for a SAP-1 core with a 2**AW x DW
// program memory. A serial bit stream (MSB first) is assembled into bytes
// that are written to consecutive addresses. The memory port is shared
// between this loader and CPU instruction fetch. The CPU is sequenced
// through hold-in-reset, free run, halt and single-step.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ser_valid       ser_data holds a valid bit this cycle
//   ser_data        serial program bit, MSB first
//   load_req        request LOAD (level)
//   run_req         request free-running RUN
//   step_req        request a single instruction, then HALT
//   halt_req        halt at the next instruction boundary, or abort LOAD
//   cpu_mem_addr    CPU MAR value
//   cpu_instr_done  CPU is in the last microstep of an instruction
//   mem_addr        memory address: CPU MAR in RUN/HALT, else load pointer
//   mem_wdata       assembled byte to write
//   mem_we          one-cycle write strobe per byte
//   cpu_rst         holds the CPU in reset (IDLE/LOAD)
//   cpu_en          CPU clock enable (RUN only)
//   state           0=IDLE 1=LOAD 2=RUN 3=HALT
//   byte_cnt        bytes written in the current/last LOAD (0..2**AW)
//   load_done       one-cycle pulse after the final byte is written
// ---------------------------------------------------------------------------
module sap_prog_loader_ctrl #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ser_valid,
    input  logic          ser_data,
    input  logic          load_req,
    input  logic          run_req,
    input  logic          step_req,
    input  logic          halt_req,
    input  logic [AW-1:0] cpu_mem_addr,
    input  logic          cpu_instr_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          cpu_rst,
    output logic          cpu_en,
    output logic [1:0]    state,
    output logic [AW:0]   byte_cnt,
    output logic          load_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DW - 1);
    // Count value while the final (top-address) byte is being written.
    localparam logic [AW:0]    BYTE_LAST = {1'b0, {AW{1'b1}}};

    logic [1:0]     state_reg, state_next;
    logic [DW-1:0]  shift_reg, shift_next;
    logic [BCW-1:0] bit_cnt_reg, bit_cnt_next;
    logic [AW:0]    byte_cnt_reg, byte_cnt_next;
    logic           mem_we_reg, mem_we_next;
    logic [DW-1:0]  mem_wdata_reg, mem_wdata_next;
    logic           load_done_reg, load_done_next;
    logic           halt_pending_reg, halt_pending_next;
    logic           step_reg, step_next;
    logic           cpu_rst_reg, cpu_rst_next;
    logic           cpu_en_reg, cpu_en_next;
    logic           final_write;

    // The write cycle of the top-address byte ends the load.
    assign final_write = mem_we_reg && (byte_cnt_reg == BYTE_LAST);

    always_comb begin
        state_next        = state_reg;
        shift_next        = shift_reg;
        bit_cnt_next      = bit_cnt_reg;
        byte_cnt_next     = byte_cnt_reg;
        mem_we_next       = 1'b0;
        mem_wdata_next    = mem_wdata_reg;
        load_done_next    = 1'b0;
        halt_pending_next = halt_pending_reg;
        step_next         = step_reg;

        case (state_reg)
            S_IDLE: begin
                // halt_req has no meaning here; lower requests still act.
                if (load_req) begin
                    state_next    = S_LOAD;
                    byte_cnt_next = '0;
                    bit_cnt_next  = '0;
                    shift_next    = '0;
                end else if (run_req) begin
                    state_next = S_RUN;
                end else if (step_req) begin
                    state_next = S_RUN;
                    step_next  = 1'b1;
                end
            end

            S_LOAD: begin
                // A byte whose strobe is already out is always committed.
                if (mem_we_reg) begin
                    byte_cnt_next = byte_cnt_reg + 1'b1;
                    if (final_write) begin
                        load_done_next = 1'b1;
                        state_next     = S_IDLE;
                    end
                end
                if (halt_req) begin
                    state_next   = S_IDLE;
                    bit_cnt_next = '0;
                    shift_next   = '0;
                end else if (ser_valid && !final_write) begin
                    shift_next = {shift_reg[DW-2:0], ser_data};
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next   = '0;
                        mem_we_next    = 1'b1;
                        mem_wdata_next = {shift_reg[DW-2:0], ser_data};
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (halt_req) begin
                    if (cpu_instr_done) begin
                        state_next        = S_HALT;
                        halt_pending_next = 1'b0;
                        step_next         = 1'b0;
                    end else begin
                        halt_pending_next = 1'b1;
                    end
                end else if (load_req) begin
                    state_next        = S_LOAD;
                    byte_cnt_next     = '0;
                    bit_cnt_next      = '0;
                    shift_next        = '0;
                    halt_pending_next = 1'b0;
                    step_next         = 1'b0;
                end else if (cpu_instr_done && (halt_pending_reg || step_reg)) begin
                    state_next        = S_HALT;
                    halt_pending_next = 1'b0;
                    step_next         = 1'b0;
                end
            end

            default: begin // S_HALT
                if (halt_req) begin
                    state_next = S_HALT;
                end else if (load_req) begin
                    state_next    = S_LOAD;
                    byte_cnt_next = '0;
                    bit_cnt_next  = '0;
                    shift_next    = '0;
                end else if (run_req) begin
                    state_next = S_RUN;
                end else if (step_req) begin
                    state_next = S_RUN;
                    step_next  = 1'b1;
                end
            end
        endcase

        // CPU controls are registered from the next state so they line up
        // with the state output.
        cpu_rst_next = (state_next == S_IDLE) || (state_next == S_LOAD);
        cpu_en_next  = (state_next == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            byte_cnt_reg     <= '0;
            mem_we_reg       <= 1'b0;
            mem_wdata_reg    <= '0;
            load_done_reg    <= 1'b0;
            halt_pending_reg <= 1'b0;
            step_reg         <= 1'b0;
            cpu_rst_reg      <= 1'b1;
            cpu_en_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            shift_reg        <= shift_next;
            bit_cnt_reg      <= bit_cnt_next;
            byte_cnt_reg     <= byte_cnt_next;
            mem_we_reg       <= mem_we_next;
            mem_wdata_reg    <= mem_wdata_next;
            load_done_reg    <= load_done_next;
            halt_pending_reg <= halt_pending_next;
            step_reg         <= step_next;
            cpu_rst_reg      <= cpu_rst_next;
            cpu_en_reg       <= cpu_en_next;
        end
    end

    assign mem_addr  = ((state_reg == S_RUN) || (state_reg == S_HALT))
                       ? cpu_mem_addr : byte_cnt_reg[AW-1:0];
    assign mem_wdata = mem_wdata_reg;
    assign mem_we    = mem_we_reg;
    assign cpu_rst   = cpu_rst_reg;
    assign cpu_en    = cpu_en_reg;
    assign state     = state_reg;
    assign byte_cnt  = byte_cnt_reg;
    assign load_done = load_done_reg;

endmodule
